// File: rtl/mem_arbiter_if.sv
// Bus bundle between the fetch/data request ports, the arbiter and the single-ported RAM.
// master is the arbiter's view; slave is the datapath-plus-RAM environment's view.
interface mem_arbiter_if;
  logic        iREN;
  logic [31:0] iaddr;
  logic [31:0] iload;
  logic        iwait;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic [31:0] dload;
  logic        dwait;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic [1:0]  ramstate;
  logic        dgrant;
  logic        timeout;

  modport master (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iload, iwait, dload, dwait, ramREN, ramWEN, ramaddr, ramstore,
           dgrant, timeout
  );

  modport slave (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iload, iwait, dload, dwait, ramREN, ramWEN, ramaddr, ramstore,
           dgrant, timeout
  );
endinterface

// File: rtl/mem_arbiter.sv
// Single-transaction arbiter of instruction fetch and data access onto one RAM port.
// Data has priority, bounded by a streak limit; a watchdog aborts unresponsive serves.
module mem_arbiter #(
  parameter int unsigned MAX_DSTREAK = 4,
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input logic          CLK,
  input logic          nRST,
  mem_arbiter_if.master bus
);

  localparam int unsigned SW = (MAX_DSTREAK < 1) ? 1 : $clog2(MAX_DSTREAK + 1);
  localparam int unsigned WW = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);
  localparam logic [SW-1:0] SMAX = SW'(MAX_DSTREAK);
  localparam logic [WW-1:0] WMAX = WW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} state_t;
  typedef enum logic [1:0] {RAM_FREE, RAM_BUSY, RAM_ACCESS, RAM_ERROR} ram_state_t;

  state_t      state, next_state;
  logic [SW-1:0] streak, next_streak;
  logic [WW-1:0] wdog, next_wdog;
  logic        timeout_q, next_timeout;
  logic        dgrant_q;

  ram_state_t  rs;
  logic        dreq;
  logic        owner_req;
  logic        done;
  logic        i_done, d_done;
  logic        ram_ren, ram_wen;
  logic [31:0] ram_addr, ram_store;

  assign rs   = ram_state_t'(bus.ramstate);
  assign dreq = bus.dREN | bus.dWEN;

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state     <= IDLE;
      streak    <= '0;
      wdog      <= '0;
      timeout_q <= 1'b0;
      dgrant_q  <= 1'b0;
    end else begin
      state     <= next_state;
      streak    <= next_streak;
      wdog      <= next_wdog;
      timeout_q <= next_timeout;
      dgrant_q  <= (next_state == SERVE_D);
    end
  end

  always_comb begin
    next_state   = state;
    next_streak  = streak;
    next_wdog    = wdog;
    next_timeout = timeout_q;
    owner_req    = 1'b0;
    done         = 1'b0;
    ram_ren      = 1'b0;
    ram_wen      = 1'b0;
    ram_addr     = '0;
    ram_store    = '0;

    case (state)
      IDLE: begin
        next_wdog = '0;
        if (dreq && !(bus.iREN && streak == SMAX)) next_state = SERVE_D;
        else if (bus.iREN)                         next_state = SERVE_I;
        else                                       next_streak = '0;
      end
      SERVE_I: begin
        owner_req = bus.iREN;
        ram_ren   = bus.iREN;
        ram_addr  = bus.iaddr;
      end
      SERVE_D: begin
        owner_req = dreq;
        ram_addr  = bus.daddr;
        ram_store = bus.dstore;
        ram_wen   = bus.dWEN;
        ram_ren   = bus.dREN & ~bus.dWEN;
      end
      default: next_state = IDLE;
    endcase

    // Shared serve-state sequencing: abort, completion, then watchdog/error.
    if (state == SERVE_I || state == SERVE_D) begin
      if (!owner_req) begin
        next_state = IDLE;
      end else if (rs == RAM_ACCESS) begin
        done       = 1'b1;
        next_state = IDLE;
        next_wdog  = '0;
        if (state == SERVE_D && bus.iREN)
          next_streak = (streak == SMAX) ? SMAX : streak + 1'b1;
        else
          next_streak = '0;
      end else begin
        next_wdog = wdog + 1'b1;
        if (rs == RAM_ERROR || wdog == WMAX) begin
          next_timeout = 1'b1;
          next_state   = IDLE;
          next_wdog    = '0;
        end
      end
    end

    // Reset takes effect on the outputs immediately, not only after the edge.
    if (!nRST) begin
      done    = 1'b0;
      ram_ren = 1'b0;
      ram_wen = 1'b0;
      ram_addr  = '0;
      ram_store = '0;
    end
  end

  assign i_done = done && (state == SERVE_I);
  assign d_done = done && (state == SERVE_D);

  assign bus.iload    = bus.ramload;
  assign bus.dload    = bus.ramload;
  assign bus.iwait    = bus.iREN & ~i_done;
  assign bus.dwait    = dreq & ~d_done;
  assign bus.ramREN   = ram_ren;
  assign bus.ramWEN   = ram_wen;
  assign bus.ramaddr  = ram_addr;
  assign bus.ramstore = ram_store;
  assign bus.dgrant   = dgrant_q;
  assign bus.timeout  = timeout_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with MAX_DSTREAK=4, TIMEOUT_CYC=8.
// Inputs change 1 time unit after the rising edge; outputs are sampled mid-cycle.
module tb_mem_arbiter;

  logic CLK = 1'b0;
  logic nRST;
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  mem_arbiter_if bus ();

  mem_arbiter #(.MAX_DSTREAK(4), .TIMEOUT_CYC(8)) dut (
    .CLK (CLK),
    .nRST(nRST),
    .bus (bus.master)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_inputs();
    bus.iREN = 1'b0; bus.iaddr = '0;
    bus.dREN = 1'b0; bus.dWEN = 1'b0; bus.daddr = '0; bus.dstore = '0;
    bus.ramload = '0; bus.ramstate = 2'd0;
  endtask

  initial begin
    logic [31:0] dmask, imask, gmask;
    int unsigned ren_cnt;

    clear_inputs();
    nRST = 1'b0;
    tick();
    tick();

    // Reset values, observed while nRST is still low
    bus.iREN = 1'b1; bus.dREN = 1'b1; bus.ramload = 32'h0000_1234;
    #2;
    check("rst_iwait",   bus.iwait,   1);
    check("rst_dwait",   bus.dwait,   1);
    check("rst_ramREN",  bus.ramREN,  0);
    check("rst_ramWEN",  bus.ramWEN,  0);
    check("rst_ramaddr", bus.ramaddr, 0);
    check("rst_ramstore",bus.ramstore,0);
    check("rst_dgrant",  bus.dgrant,  0);
    check("rst_timeout", bus.timeout, 0);
    check("rst_iload",   bus.iload,   32'h0000_1234);
    check("rst_dload",   bus.dload,   32'h0000_1234);
    clear_inputs();
    nRST = 1'b1;
    tick();

    // Fetch only: ACCESS on third serve cycle
    bus.iREN = 1'b1; bus.iaddr = 32'h40;
    #2;
    check("f_bubble_ren", bus.ramREN, 0);
    check("f_bubble_iw",  bus.iwait,  1);
    tick();
    bus.ramstate = 2'd1;
    #2;
    check("f_s1_ren",  bus.ramREN,  1);
    check("f_s1_addr", bus.ramaddr, 32'h40);
    check("f_s1_iw",   bus.iwait,   1);
    tick();
    #2;
    check("f_s2_ren", bus.ramREN, 1);
    check("f_s2_iw",  bus.iwait,  1);
    tick();
    bus.ramstate = 2'd2; bus.ramload = 32'h8C22_0004;
    #2;
    check("f_s3_ren",   bus.ramREN, 1);
    check("f_s3_iw",    bus.iwait,  0);
    check("f_s3_iload", bus.iload,  32'h8C22_0004);
    tick();
    clear_inputs();
    #2;
    check("f_idle_ren",    bus.ramREN, 0);
    check("f_idle_dgrant", bus.dgrant, 0);
    tick();

    // Conflict: data first, fetch two cycles later
    bus.iREN = 1'b1; bus.iaddr = 32'h44; bus.dREN = 1'b1; bus.daddr = 32'h100;
    #2;
    check("c_idle_ren",    bus.ramREN, 0);
    check("c_idle_dgrant", bus.dgrant, 0);
    tick();
    bus.ramstate = 2'd2; bus.ramload = 32'h11;
    #2;
    check("c_d_dgrant", bus.dgrant,  1);
    check("c_d_addr",   bus.ramaddr, 32'h100);
    check("c_d_ren",    bus.ramREN,  1);
    check("c_d_dwait",  bus.dwait,   0);
    check("c_d_dload",  bus.dload,   32'h11);
    check("c_d_iwait",  bus.iwait,   1);
    tick();
    bus.dREN = 1'b0; bus.ramstate = 2'd0;
    #2;
    check("c_idle2_iw",  bus.iwait,  1);
    check("c_idle2_ren", bus.ramREN, 0);
    tick();
    bus.ramstate = 2'd2; bus.ramload = 32'h22;
    #2;
    check("c_i_iwait", bus.iwait,   0);
    check("c_i_addr",  bus.ramaddr, 32'h44);
    check("c_i_iload", bus.iload,   32'h22);
    tick();
    clear_inputs();
    tick();

    // Write wins over read; store path
    bus.dREN = 1'b1; bus.dWEN = 1'b1; bus.daddr = 32'h200; bus.dstore = 32'hDEAD_BEEF;
    #2;
    check("w_idle_dwait", bus.dwait, 1);
    tick();
    bus.ramstate = 2'd1;
    #2;
    check("w_wen",   bus.ramWEN,   1);
    check("w_ren",   bus.ramREN,   0);
    check("w_store", bus.ramstore, 32'hDEAD_BEEF);
    check("w_addr",  bus.ramaddr,  32'h200);
    check("w_dwait", bus.dwait,    1);
    tick();
    bus.ramstate = 2'd2;
    #2;
    check("w_done_dwait", bus.dwait, 0);
    tick();
    clear_inputs();
    #2;
    check("w_idle_wen", bus.ramWEN, 0);
    tick();

    // Starvation bound: 4 data grants, one fetch, data resumes (22-cycle window)
    dmask = '0; imask = '0; gmask = '0;
    bus.iREN = 1'b1; bus.iaddr = 32'h80; bus.dREN = 1'b1; bus.daddr = 32'h300;
    bus.ramstate = 2'd2;
    for (int c = 0; c < 22; c++) begin
      #2;
      if (!bus.dwait) dmask[c] = 1'b1;
      if (!bus.iwait) imask[c] = 1'b1;
      if (bus.dgrant) gmask[c] = 1'b1;
      tick();
    end
    check("s_data_done_mask",  dmask, 32'h0022_A8AA);
    check("s_fetch_done_mask", imask, 32'h0008_0200);
    check("s_dgrant_mask",     gmask, 32'h0022_A8AA);
    clear_inputs();
    tick();

    // Watchdog: RAM held BUSY for 8 serve cycles
    bus.iREN = 1'b1; bus.iaddr = 32'h500; bus.ramstate = 2'd1;
    tick();
    ren_cnt = 0;
    for (int k = 0; k < 8; k++) begin
      #2;
      if (bus.ramREN) ren_cnt++;
      if (k == 7) check("wd_pre_timeout", bus.timeout, 0);
      tick();
    end
    check("wd_serve_cycles", ren_cnt, 8);
    #2;
    check("wd_timeout", bus.timeout, 1);
    check("wd_idle_ren", bus.ramREN, 0);
    check("wd_iwait",   bus.iwait,   1);
    tick();
    #2;
    check("wd_regrant_ren",  bus.ramREN,  1);
    check("wd_regrant_addr", bus.ramaddr, 32'h500);
    bus.ramstate = 2'd2; bus.ramload = 32'hCAFE_0001;
    #1;
    check("wd_regrant_iw",  bus.iwait, 0);
    check("wd_regrant_ld",  bus.iload, 32'hCAFE_0001);
    tick();
    clear_inputs();
    nRST = 1'b0;
    tick();
    nRST = 1'b1;
    #2;
    check("wd_cleared_by_rst", bus.timeout, 0);

    // ERROR on first serve cycle
    bus.dREN = 1'b1; bus.daddr = 32'h600;
    tick();
    bus.ramstate = 2'd3;
    #2;
    check("er_pre_timeout", bus.timeout, 0);
    check("er_dwait",       bus.dwait,   1);
    check("er_dgrant",      bus.dgrant,  1);
    tick();
    #2;
    check("er_timeout", bus.timeout, 1);
    check("er_dgrant0", bus.dgrant,  0);
    clear_inputs();
    tick();
    nRST = 1'b0;
    tick();
    nRST = 1'b1;

    // Mid-serve reset
    bus.dREN = 1'b1; bus.daddr = 32'h700; bus.ramstate = 2'd1;
    tick();
    #2;
    check("mr_dgrant", bus.dgrant,  1);
    check("mr_ren",    bus.ramREN,  1);
    check("mr_addr",   bus.ramaddr, 32'h700);
    nRST = 1'b0; bus.ramstate = 2'd2;
    #1;
    check("mr_rst_dwait", bus.dwait, 1);
    tick();
    nRST = 1'b1; bus.ramstate = 2'd1;
    #2;
    check("mr_post_ren",     bus.ramREN,  0);
    check("mr_post_wen",     bus.ramWEN,  0);
    check("mr_post_dgrant",  bus.dgrant,  0);
    check("mr_post_timeout", bus.timeout, 0);

    // Abort: dWEN dropped mid-serve while a fetch waits
    bus.dREN = 1'b0; bus.dWEN = 1'b1; bus.daddr = 32'h710; bus.dstore = 32'h5555;
    bus.iREN = 1'b1; bus.iaddr = 32'h720;
    tick();
    #2;
    check("ab_wen",   bus.ramWEN,   1);
    check("ab_store", bus.ramstore, 32'h5555);
    check("ab_iwait", bus.iwait,    1);
    bus.dWEN = 1'b0; bus.ramstate = 2'd2;
    #1;
    check("ab_drop_wen", bus.ramWEN, 0);
    check("ab_drop_ren", bus.ramREN, 0);
    check("ab_drop_iw",  bus.iwait,  1);
    tick();
    bus.ramstate = 2'd0;
    #2;
    check("ab_idle_dgrant", bus.dgrant, 0);
    check("ab_idle_ren",    bus.ramREN, 0);
    check("ab_idle_iw",     bus.iwait,  1);
    tick();
    #2;
    check("ab_fetch_ren",  bus.ramREN,  1);
    check("ab_fetch_addr", bus.ramaddr, 32'h720);
    check("ab_fetch_dw",   bus.dwait,   0);
    clear_inputs();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Arbitrates the pipeline's instruction-fetch port and data-memory port onto one single-ported RAM.
- Sits between the datapath's cache-side request signals and the RAM model.
- Serves one transaction at a time. Data requests have priority.
- A bounded-streak rule guarantees instruction fetch is never starved. A watchdog flags a RAM that never responds.

Parameters:
- MAX_DSTREAK, 4, max consecutive data grants while a fetch is pending before one fetch grant is forced (min 1).
- TIMEOUT_CYC, 64, cycles in a serve state without ACCESS before abort (min 2).

Ports:
- CLK  in  1  clock, rising edge
- nRST  in  1  reset, synchronous, active-low
- iREN  in  1  instruction read request
- iaddr  in  32  instruction address
- iload  out  32  instruction data
- iwait  out  1  fetch not complete this cycle
- dREN  in  1  data read request
- dWEN  in  1  data write request
- daddr  in  32  data address
- dstore  in  32  write data
- dload  out  32  read data
- dwait  out  1  data access not complete this cycle
- ramREN  out  1  RAM read enable
- ramWEN  out  1  RAM write enable
- ramaddr  out  32  RAM address
- ramstore  out  32  RAM write data
- ramload  in  32  RAM read data
- ramstate  in  2  0=FREE, 1=BUSY, 2=ACCESS, 3=ERROR
- dgrant  out  1  registered: 1 while in SERVE_D
- timeout  out  1  sticky watchdog/error flag

Behaviour:
- Reset: one clock; reset is synchronous and active-low (CLK, nRST). With nRST low at a rising edge:
  - state <= IDLE; streak <= 0; wdog <= 0; timeout <= 0.
  - Effect is immediate even mid-transaction; RAM enables are 0 from the next cycle.
  - Reset output values: ramREN = ramWEN = 0, ramaddr = 0, ramstore = 0, dgrant = 0, timeout = 0.
  - During reset: iwait = iREN, dwait = (dREN | dWEN); iload = dload = ramload.
- States: IDLE, SERVE_I, SERVE_D.
- IDLE (arbitration, one-cycle bubble): RAM enables 0, ramaddr = 0, ramstore = 0.
  - If (dREN | dWEN) and !(iREN && streak == MAX_DSTREAK) -> SERVE_D.
  - Else if iREN -> SERVE_I.
  - Else stay in IDLE and clear streak.
- SERVE_I:
  - ramREN = iREN, ramWEN = 0, ramaddr = iaddr, ramstore = 0.
- SERVE_D:
  - ramaddr = daddr, ramstore = dstore.
  - If dWEN: ramWEN = 1, ramREN = 0. Write wins if both dREN and dWEN are asserted.
  - Else ramREN = dREN.
- Completion: owner request high and ramstate == ACCESS (combinational, same cycle).
  - Owner's wait = 0 for exactly that cycle; load data = ramload in that cycle.
  - Next state is IDLE; wdog <= 0.
- Latency: min 2 cycles from request to completion (IDLE bubble + ACCESS in first serve cycle).
- Wait outputs: iwait = iREN & !(SERVE_I completion); dwait = (dREN|dWEN) & !(SERVE_D completion). The non-owner always waits.
- Loads: iload and dload are both wired to ramload at all times; they are valid only on the owner's completion cycle.
- Streak counter, width $clog2(MAX_DSTREAK+1):
  - On SERVE_D completion: +1 if iREN is high, else cleared; saturates at MAX_DSTREAK.
  - Cleared on SERVE_I completion.
- Abort: owner request drops before ACCESS.
  - RAM enables are 0 that cycle; next state IDLE; no completion is signalled; streak is unchanged.
- Watchdog:
  - wdog increments on every serve cycle that is not a completion.
  - When wdog reaches TIMEOUT_CYC - 1 without ACCESS, or when ramstate == ERROR: timeout <= 1, next state IDLE, wdog <= 0.
  - The requester keeps waiting and is re-arbitrated.
  - timeout is cleared only by reset.
- Simultaneous requests in IDLE with streak below the limit: data wins.
- Back-to-back requests from the same requester: a new IDLE bubble is inserted every time.

Test Plan:
- Fetch only: iREN=1, iaddr=0x40, RAM gives ACCESS on the 3rd serve cycle with ramload=0x8C220004 -> iwait=0 on exactly cycle 4 after the request, iload=0x8C220004, then back to IDLE; ramREN high only during the 3 serve cycles.
- Conflict: iREN and dREN asserted together, daddr=0x100, 1-cycle RAM -> data completes first (dgrant=1, ramaddr=0x100), fetch completes 2 cycles later; iwait stays 1 throughout the data transaction.
- Write priority and store path: dREN=dWEN=1, dstore=0xDEADBEEF, daddr=0x200 -> ramWEN=1, ramREN=0, ramstore=0xDEADBEEF; dwait drops on ACCESS.
- Starvation bound: MAX_DSTREAK=4, continuous data requests plus iREN held -> exactly 4 data completions, then one fetch grant, then data resumes; streak reads 0 after the fetch completes.
- Watchdog: TIMEOUT_CYC=8, RAM held BUSY -> timeout=1 after 8 serve cycles, FSM returns to IDLE, request is re-granted; separately, ramstate=3 on the first serve cycle sets timeout immediately.
- Mid-operation reset and abort: nRST low during SERVE_D -> next cycle state is IDLE with all RAM enables 0 and timeout 0; dWEN dropped mid-serve -> no dwait=0 pulse, state returns to IDLE.
